tt_um_seq_checker: RTL and testbench

Receive-side companion to the incrementing-counter tile: samples an 8-bit stream on `ui_in`, checks each qualified sample equals previous+1 (mod 256), tracks lock with a small state machine, and reports saturating good/error counts. Sits at the Tiny Tapeout user-tile boundary and uses the standard tile pinout. The bidirectional pins carry inputs on the low nibble and status outputs on the high nibble.

---
 rtl/seq_chk_pkg.sv | 21 ++
 rtl/sat_counter8.sv | 31 +++
 rtl/tt_um_seq_checker.sv | 133 +++++++++++++
 tb/tb_tt_um_seq_checker.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seq_chk_pkg.sv
// Shared encodings for the sequence checker tile: FSM states, uio bit positions, pad directions.
package seq_chk_pkg;

    typedef enum logic [1:0] {
        StHunt   = 2'b00,
        StAcq    = 2'b01,
        StLocked = 2'b10
    } state_e;

    localparam int unsigned UioValid   = 0;
    localparam int unsigned UioClear   = 1;
    localparam int unsigned UioSel     = 2;
    localparam int unsigned UioStateLo = 4;
    localparam int unsigned UioStateHi = 5;
    localparam int unsigned UioSticky  = 6;
    localparam int unsigned UioMatch   = 7;

    // Low nibble of uio is input, high nibble drives status.
    localparam logic [7:0] UioOe = 8'hF0;

endpackage

// File: rtl/sat_counter8.sv
// 8-bit event counter that sticks at FF; clear beats increment.
module sat_counter8 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [7:0] cnt_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'h00;
        end else if (inc_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tt_um_seq_checker.sv
// Receive-side checker for an incrementing 8-bit stream: lock FSM plus good/error counters.
module tt_um_seq_checker
    import seq_chk_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_e     state_q, state_d;
    logic [7:0] prev_q, prev_d;
    logic [3:0] run_q, run_d;
    logic [3:0] miss_q, miss_d;
    logic       sticky_q, sticky_d;
    logic       match_q, match_d;
    logic       good_inc, err_inc;
    logic [7:0] good_cnt, err_cnt;

    logic valid, clear, sel, match, is_hunt;
    logic [3:0] run_inc, miss_inc;

    assign valid    = uio_in[UioValid];
    assign clear    = uio_in[UioClear];
    assign sel      = uio_in[UioSel];
    assign match    = (ui_in == prev_q + 8'd1);
    assign is_hunt  = (state_q != StAcq) && (state_q != StLocked);
    assign run_inc  = run_q + 4'd1;
    assign miss_inc = miss_q + 4'd1;

    logic unused_ok;
    assign unused_ok = ^{ena, uio_in[7:3]};

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        run_d    = run_q;
        miss_d   = miss_q;
        good_inc = 1'b0;
        err_inc  = 1'b0;
        if (valid) begin
            case (state_q)
                StAcq: begin
                    prev_d = ui_in;
                    if (match) begin
                        run_d = run_inc;
                        if (run_inc == 4'(LOCK_COUNT)) begin
                            state_d = StLocked;
                            miss_d  = 4'd0;
                        end
                    end else begin
                        run_d = 4'd0;
                    end
                end
                StLocked: begin
                    // Flywheel: expected value advances regardless of what arrived.
                    prev_d = prev_q + 8'd1;
                    if (match) begin
                        good_inc = 1'b1;
                        miss_d   = 4'd0;
                    end else begin
                        err_inc = 1'b1;
                        miss_d  = miss_inc;
                        if (miss_inc == 4'(LOSS_COUNT)) begin
                            state_d = StAcq;
                            run_d   = 4'd0;
                            prev_d  = ui_in;
                        end
                    end
                end
                default: begin
                    prev_d  = ui_in;
                    run_d   = 4'd0;
                    state_d = StAcq;
                end
            endcase
        end
        match_d  = valid & match & ~is_hunt;
        sticky_d = clear ? 1'b0 : (sticky_q | err_inc);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StHunt;
            prev_q   <= 8'h00;
            run_q    <= 4'd0;
            miss_q   <= 4'd0;
            sticky_q <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            run_q    <= run_d;
            miss_q   <= miss_d;
            sticky_q <= sticky_d;
            match_q  <= match_d;
        end
    end

    sat_counter8 u_good_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (clear),
        .inc_i  (good_inc),
        .cnt_o  (good_cnt)
    );

    sat_counter8 u_err_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (clear),
        .inc_i  (err_inc),
        .cnt_o  (err_cnt)
    );

    assign uo_out = sel ? err_cnt : good_cnt;
    assign uio_oe = UioOe;

    always_comb begin
        uio_out                        = 8'h00;
        uio_out[UioStateHi:UioStateLo] = state_q;
        uio_out[UioSticky]             = sticky_q;
        uio_out[UioMatch]              = match_q;
    end

endmodule

// File: tb/tb_tt_um_seq_checker.sv
// Directed bench for tt_um_seq_checker: lock, wrap, glitch, loss, clear, saturation, reset.
module tb_tt_um_seq_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tt_um_seq_checker #(
        .LOCK_COUNT (4),
        .LOSS_COUNT (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // One clock with the given valid/clear/sample; returns 1ns after the edge.
    task automatic drive(input logic v, input logic c, input logic [7:0] d);
        @(negedge clk);
        uio_in = {6'b0, c, v};
        ui_in  = d;
        @(posedge clk);
        #1;
        uio_in = 8'h00;
    endtask

    // Expected uio_out: {match, sticky, state[1:0], 4'b0}.
    task automatic chk_st(input string tag, input logic [1:0] st, input logic stk,
                          input logic m);
        chk({tag, " status"}, uio_out, {m, stk, st, 4'b0000});
    endtask

    task automatic chk_cnt(input string tag, input logic [7:0] good, input logic [7:0] err);
        uio_in[2] = 1'b0;
        #1;
        chk({tag, " good"}, uo_out, good);
        uio_in[2] = 1'b1;
        #1;
        chk({tag, " err"}, uo_out, err);
        uio_in[2] = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // Reset with random inputs
        repeat (2) begin
            @(negedge clk);
            ui_in  = 8'($urandom);
            uio_in = 8'($urandom);
        end
        @(posedge clk);
        #1;
        chk("reset uo_out", uo_out, 8'h00);
        chk("reset uio_out", uio_out, 8'h00);
        chk("reset uio_oe", uio_oe, 8'hF0);
        @(negedge clk);
        uio_in = 8'h00;
        ui_in  = 8'h00;
        rst_n  = 1'b1;

        // Acquire
        drive(1, 0, 8'h10);
        chk_st("acq 10", 2'b01, 0, 0);
        drive(1, 0, 8'h11);
        chk_st("acq 11", 2'b01, 0, 1);
        drive(1, 0, 8'h12);
        drive(1, 0, 8'h13);
        chk_st("acq 13", 2'b01, 0, 1);
        drive(1, 0, 8'h14);
        chk_st("lock 14", 2'b10, 0, 1);
        chk_cnt("lock 14", 8'h00, 8'h00);
        drive(1, 0, 8'h15);
        chk_st("locked 15", 2'b10, 0, 1);
        chk_cnt("locked 15", 8'h01, 8'h00);

        // Run up to FD, then wrap through FF->00
        for (int i = 8'h16; i <= 8'hFD; i++) drive(1, 0, 8'(i));
        chk_cnt("run FD", 8'hE9, 8'h00);
        drive(1, 0, 8'hFE);
        drive(1, 0, 8'hFF);
        drive(1, 0, 8'h00);
        chk_st("wrap 00", 2'b10, 0, 1);
        drive(1, 0, 8'h01);
        chk_st("wrap 01", 2'b10, 0, 1);
        chk_cnt("wrap", 8'hED, 8'h00);

        // Good count saturates at FF (237 + 30 > 255)
        for (int i = 8'h02; i <= 8'h1F; i++) drive(1, 0, 8'(i));
        chk_cnt("saturate", 8'hFF, 8'h00);

        // Clear with a matching valid sample: clear wins over the increment
        drive(1, 1, 8'h20);
        chk_st("clear valid", 2'b10, 0, 1);
        chk_cnt("clear valid", 8'h00, 8'h00);

        // Single glitch; flywheel keeps 23 matching
        drive(1, 0, 8'h21);
        drive(1, 0, 8'h99);
        chk_st("glitch 99", 2'b10, 1, 0);
        chk_cnt("glitch 99", 8'h01, 8'h01);
        drive(1, 0, 8'h23);
        chk_st("glitch 23", 2'b10, 1, 1);
        chk_cnt("glitch 23", 8'h02, 8'h01);

        // Gaps in valid neither break lock nor count
        repeat (3) drive(0, 0, 8'h5A);
        chk_st("gap idle", 2'b10, 1, 0);
        drive(1, 0, 8'h24);
        chk_st("gap 24", 2'b10, 1, 1);
        chk_cnt("gap 24", 8'h03, 8'h01);

        // Clear on an idle cycle
        drive(0, 1, 8'h00);
        chk_st("clear idle", 2'b10, 0, 0);
        chk_cnt("clear idle", 8'h00, 8'h00);

        // Loss of lock after two consecutive misses, then relock
        drive(1, 0, 8'h55);
        chk_st("loss 55", 2'b10, 1, 0);
        drive(1, 0, 8'h77);
        chk_st("loss 77", 2'b01, 1, 0);
        chk_cnt("loss 77", 8'h00, 8'h02);
        drive(1, 0, 8'h78);
        drive(1, 0, 8'h79);
        drive(1, 0, 8'h7A);
        chk_st("relock 7A", 2'b01, 1, 1);
        drive(1, 0, 8'h7B);
        chk_st("relock 7B", 2'b10, 1, 1);
        chk_cnt("relock 7B", 8'h00, 8'h02);

        // Mid-stream reset discards lock
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_st("midreset", 2'b00, 0, 0);
        chk_cnt("midreset", 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 8'h7C);
        chk_st("rehunt 7C", 2'b01, 0, 0);

        // Mismatch in ACQ restarts the run count
        drive(1, 0, 8'h7D);
        drive(1, 0, 8'h7E);
        drive(1, 0, 8'h00);
        chk_st("acq miss", 2'b01, 0, 0);
        drive(1, 0, 8'h01);
        drive(1, 0, 8'h02);
        drive(1, 0, 8'h03);
        chk_st("acq run3", 2'b01, 0, 1);
        drive(1, 0, 8'h04);
        chk_st("acq run4", 2'b10, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
